gpio_nibble_tx: RTL

- FPGA-to-RPi return path: sends bytes to the Raspberry Pi over a 4-bit GPIO data bus, high nibble first.
- Each nibble uses a four-phase strobe/acknowledge handshake. The RPi drives the acknowledge line.
- Sits between FPGA result logic (byte valid/ready interface) and the RPi GPIO pins.
- Complements the existing RPi-to-FPGA GPIO input path.

---
 rtl/gpio_nibble_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/gpio_nibble_tx.sv
`timescale 1ns/1ps
// gpio_nibble_tx
// Return path from the FPGA to the Raspberry Pi. Bytes from the result logic
// are sent over a 4-bit GPIO bus, high nibble first. Each nibble uses a
// four-phase strobe/acknowledge handshake:
//   1. drive rpi_out
//   2. after SETUP_CYC cycles, raise rpi_strb
//   3. wait for ack high, then drop rpi_strb
//   4. wait for ack low
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   reset     asynchronous, active-high reset
//   tx_byte   byte to send, sampled when tx_valid & tx_ready
//   tx_valid  tx_byte is valid
//   tx_ready  block is idle and accepts a byte this cycle (combinational)
//   tx_done   one-cycle pulse, byte fully transferred
//   tx_err    one-cycle pulse, transfer aborted because the RPi did not answer
//   rpi_ack   acknowledge from the RPi, asynchronous to clk
//   rpi_out   nibble driven to the RPi
//   rpi_strb  nibble-valid strobe to the RPi
//
// Parameters:
//   SETUP_CYC    cycles rpi_out is stable before rpi_strb rises (1..255)
//   TIMEOUT_CYC  cycles allowed in an ack-wait state before abort, 0 = never
module gpio_nibble_tx #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       rpi_ack,
    output logic [3:0] rpi_out,
    output logic       rpi_strb
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT_HI,
        WAIT_LO
    } state_t;

    localparam logic [31:0] SETUP_LAST   = 32'(SETUP_CYC - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYC != 0);

    state_t      state;
    logic [3:0]  byte_lo;
    logic        nib_sel;
    logic [31:0] cnt;
    logic        ack_m;
    logic        ack_s;
    logic        timed_out;

    // The RPi answers on its own clock, so its acknowledge is brought into
    // the clk domain with two flops before the FSM ever looks at it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= rpi_ack;
            ack_s <= ack_m;
        end
    end

    assign tx_ready = (state == IDLE);

    // With TIMEOUT_CYC = 0 the counter simply wraps inside the wait states
    // and never causes an abort.
    assign timed_out = TIMEOUT_EN && (cnt == TIMEOUT_LAST);

    // Handshake sequencer. The wait states check the awaited ack level
    // before the timeout, so an ack that arrives on the last allowed cycle
    // still completes the nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rpi_out  <= 4'h0;
            rpi_strb <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            byte_lo  <= 4'h0;
            nib_sel  <= 1'b0;
            cnt      <= 32'd0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        rpi_out <= tx_byte[7:4];
                        byte_lo <= tx_byte[3:0];
                        nib_sel <= 1'b0;
                        cnt     <= 32'd0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        rpi_strb <= 1'b1;
                        cnt      <= 32'd0;
                        state    <= WAIT_HI;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_HI: begin
                    if (ack_s) begin
                        rpi_strb <= 1'b0;
                        cnt      <= 32'd0;
                        state    <= WAIT_LO;
                    end else if (timed_out) begin
                        tx_err   <= 1'b1;
                        rpi_strb <= 1'b0;
                        cnt      <= 32'd0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAIT_LO: begin
                    if (!ack_s) begin
                        cnt <= 32'd0;
                        if (!nib_sel) begin
                            rpi_out <= byte_lo;
                            nib_sel <= 1'b1;
                            state   <= SETUP;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end else if (timed_out) begin
                        tx_err   <= 1'b1;
                        rpi_strb <= 1'b0;
                        cnt      <= 32'd0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
